// File: rtl/wb_regfile.sv
// Write-back stage with int/float register files, fetch PC sequencing and retire counter.
// Optional WB_REGFILE_BYPASS_EN: read ports return same-cycle write data (write-first).
module wb_regfile (
    input  logic        clk,
    input  logic        rstn,
    input  logic        done,
    input  logic [2:0]  wselector,
    input  logic [31:0] data,
    input  logic [4:0]  rd_out,
    input  logic [31:0] pc_out,
    input  logic        stall_enable,
    input  logic [4:0]  rs_no,
    input  logic [4:0]  rt_no,
    input  logic        fmode1,
    input  logic        fmode2,
    output logic [31:0] rs,
    output logic [31:0] rt,
    output logic [31:0] pc,
    output logic        fetch_enable,
    output logic [31:0] retired
);

    logic [31:0] int_rf_r   [32];
    logic [31:0] float_rf_r [32];
    logic [31:0] pc_r;
    logic [31:0] retired_r;
    logic        fetch_r;
    logic        started_r;
    logic        wr_en_s;
    logic        inc_s;
    logic [31:0] pc_next_s;
    logic        rs_hit_s;
    logic        rt_hit_s;
    logic [31:0] rs_s;
    logic [31:0] rt_s;

    // Decode the done strobe into write enable, retire increment and next PC
    always_comb begin
        wr_en_s   = 1'b0;
        inc_s     = 1'b0;
        pc_next_s = pc_r;
        if (done) begin
            inc_s   = ~stall_enable;
            // started_r low means the first edge after reset: in-flight write is dropped
            wr_en_s = started_r & ~stall_enable & wselector[1];
            if (stall_enable || wselector[2]) begin
                pc_next_s = {pc_out[31:2], 2'b00};
            end else begin
                pc_next_s = pc_r + 32'd4;
            end
        end else begin
            wr_en_s   = 1'b0;
            inc_s     = 1'b0;
            pc_next_s = pc_r;
        end
    end

    // PC, retire counter, fetch pulse and startup flag
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pc_r      <= 32'd0;
            retired_r <= 32'd0;
            fetch_r   <= 1'b0;
            started_r <= 1'b0;
        end else begin
            pc_r      <= pc_next_s;
            retired_r <= retired_r + {31'd0, inc_s};
            fetch_r   <= done | ~started_r;
            started_r <= 1'b1;
        end
    end

    // Register file storage; int r0 is never written
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < 32; i++) begin
                int_rf_r[i]   <= 32'd0;
                float_rf_r[i] <= 32'd0;
            end
        end else if (wr_en_s) begin
            if (wselector[0]) begin
                float_rf_r[rd_out] <= data;
            end else if (rd_out != 5'd0) begin
                int_rf_r[rd_out] <= data;
            end
        end
    end

`ifdef WB_REGFILE_BYPASS_EN
    assign rs_hit_s = wr_en_s && (wselector[0] == fmode1) && (rd_out == rs_no);
    assign rt_hit_s = wr_en_s && (wselector[0] == fmode2) && (rd_out == rt_no);
`else
    assign rs_hit_s = 1'b0;
    assign rt_hit_s = 1'b0;
`endif

    // Read port rs
    always_comb begin
        if (!fmode1 && rs_no == 5'd0) begin
            rs_s = 32'd0;
        end else if (rs_hit_s) begin
            rs_s = data;
        end else if (fmode1) begin
            rs_s = float_rf_r[rs_no];
        end else begin
            rs_s = int_rf_r[rs_no];
        end
    end

    // Read port rt
    always_comb begin
        if (!fmode2 && rt_no == 5'd0) begin
            rt_s = 32'd0;
        end else if (rt_hit_s) begin
            rt_s = data;
        end else if (fmode2) begin
            rt_s = float_rf_r[rt_no];
        end else begin
            rt_s = int_rf_r[rt_no];
        end
    end

    assign rs           = rs_s;
    assign rt           = rt_s;
    assign pc           = pc_r;
    assign fetch_enable = fetch_r;
    assign retired      = retired_r;

endmodule

// File: doc/wb_regfile.md
WB_REGFILE -- requirements
Module: wb_regfile

Interface
REQ-001 Reset is asynchronous and active-low; one clock; all state is clocked on the rising edge of clk.
REQ-002 clk  in  1  system clock.
REQ-003 rstn  in  1  asynchronous active-low reset.
REQ-004 done  in  1  exec completion strobe; 1-cycle pulse.
REQ-005 wselector  in  3  write-back selector:
- [2] PC redirect
- [1] register write
- [0] float file (1) / int file (0)
REQ-006 data  in  32  write-back data.
REQ-007 rd_out  in  5  destination register number.
REQ-008 pc_out  in  32  redirect target.
REQ-009 stall_enable  in  1  exec refused the instruction; refetch from pc_out.
REQ-010 rs_no, rt_no  in  5 each  read addresses.
REQ-011 fmode1, fmode2  in  1 each  read port selects float file (1) or int file (0).
REQ-012 rs, rt  out  32 each  combinational read data.
REQ-013 pc  out  32  current fetch PC.
REQ-014 fetch_enable  out  1  1-cycle pulse requesting fetch at pc.
REQ-015 retired  out  32  count of completed, non-stalled instructions.

Function
REQ-016 Storage is two 32x32 register files, int and float.
REQ-017 Int register 0 reads 0 always; writes to int register 0 are discarded.
REQ-018 Float register 0 is an ordinary register.
REQ-019 On a done cycle with wselector[1]=1 and stall_enable=0, data is written at the closing edge to the file selected by wselector[0], index rd_out.
REQ-020 PC update on a done cycle, at the closing edge:
- stall_enable=1 -> pc<=pc_out
- else wselector[2]=1 -> pc<=pc_out
- else pc<=pc+4 (wraps modulo 2^32)
REQ-021 stall_enable=1 suppresses any register write and any increment of retired.
REQ-022 fetch_enable is registered; it is 1 exactly in the cycle after every done cycle, else 0.
REQ-023 Startup: fetch_enable pulses once in the first cycle after rstn deasserts (pc=0); a one-bit started flag enforces this.
REQ-024 done with wselector=000 (SW, OUT, etc.): no write, pc<=pc+4, retired increments.
REQ-025 retired increments by 1 per non-stalled done and wraps at 2^32.
REQ-026 done asserted while fetch_enable=1 is accepted normally; no event is dropped.
REQ-027 wselector, data, rd_out, pc_out and stall_enable are ignored when done=0.
REQ-028 Bits [1:0] of pc_out are forced to 00 when loaded into pc.

Reset
REQ-029 rstn low clears the following immediately, independent of clk:
- pc=0
- fetch_enable=0
- retired=0
- started=0
- all 64 registers=0
REQ-030 Reset mid-operation discards any in-flight write; the first edge after release performs no write.

Configuration
REQ-031 Macro WB_REGFILE_BYPASS_EN controls read/write bypass.
- Defined: a read port whose file/address matches the current qualifying write (REQ-019) returns data in that same cycle (write-first).
- Undefined: read ports return the stored value (read-old).
- Int register 0 always reads 0 in both cases.

Verification
REQ-032 Release reset, no done -> fetch_enable=1 in cycle 1 only, pc=0, retired=0.
REQ-033 done, wselector=010, rd_out=5, data=0x12345678; next cycle rs_no=5, fmode1=0 -> rs=0x12345678, pc=4, fetch_enable=1, retired=1.
REQ-034 done, wselector=010, rd_out=0, data=0xFFFFFFFF -> int r0 still reads 0; done, wselector=011, rd_out=0, data=0x3F800000 -> float f0 reads 0x3F800000.
REQ-035 Redirect and stall, starting from pc=0x100:
- done, wselector=110, pc_out=0x203, rd_out=31, data=0x104 -> pc=0x200, r31=0x104.
- then done, stall_enable=1, wselector=010, pc_out=0x80 -> pc=0x80, no write, retired unchanged.
REQ-036 pc=0xFFFFFFFC, done, wselector=000 -> pc=0; retired=0xFFFFFFFF, done -> retired=0.
REQ-037 With WB_REGFILE_BYPASS_EN: same-cycle write r7=0xAA and read rs_no=7 -> rs=0xAA. Without it -> rs shows the old value.
